// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch/sequencing stage; owns pc and zf, fetches op
//            words over req/ack and applies decoder branch results.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int PC_W = 8,
    parameter int OP_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [OP_W-1:0] imem_rdata,
    output logic [OP_W-1:0] op,
    output logic            op_valid,
    input  logic            exec_done,
    input  logic [PC_W-1:0] pc_in,
    input  logic            pc_we,
    input  logic            alu_zf,
    input  logic            zf_we,
    output logic            zf,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            zf_q, zf_d;
    logic            halted_q, halted_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            op_q     <= '0;
            zf_q     <= 1'b0;
            halted_q <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            zf_q     <= zf_d;
            halted_q <= halted_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        zf_d     = zf_q;
        halted_d = halted_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    op_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (zf_we) zf_d = alu_zf;
                    // A jump to itself is the program's way of signalling completion.
                    if (pc_we && (pc_in == pc_q)) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pc_d    = pc_we ? pc_in : pc_q + PC_W'(1);
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (!run) begin
                    halted_d = 1'b0;
                    pc_d     = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Strobes are registered from the next state so outputs carry no input path.
        req_d   = (state_d == S_FETCH);
        valid_d = (state_d == S_EXEC);
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign op        = op_q;
    assign op_valid  = valid_q;
    assign zf        = zf_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit with address/op scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    localparam int PC_W = 8;
    localparam int OP_W = 16;

    logic            clk = 1'b0;
    logic            rst_n, run, imem_ack, exec_done, pc_we, alu_zf, zf_we;
    logic            imem_req, op_valid, zf, halted;
    logic [PC_W-1:0] imem_addr, pc_in, pc;
    logic [OP_W-1:0] imem_rdata, op;

    int n_vec = 0;
    int n_err = 0;

    logic [PC_W-1:0] q_addr[$];
    logic [OP_W-1:0] q_op[$];
    logic [PC_W-1:0] m_pc;
    logic            m_zf;

    logic [PC_W-1:0] obs_addr;
    logic [OP_W-1:0] obs_op, obs_op_hold;
    logic            obs_valid, obs_req_exec, obs_stable;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(PC_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .op         (op),
        .op_valid   (op_valid),
        .exec_done  (exec_done),
        .pc_in      (pc_in),
        .pc_we      (pc_we),
        .alu_zf     (alu_zf),
        .zf_we      (zf_we),
        .zf         (zf),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH: ack after `waits` cycles, exec_done
    // `edly` cycles after op_valid; captures what the DUT showed along the way.
    task automatic do_instr(input int waits, input int edly, input logic [OP_W-1:0] word,
                            input logic br, input logic [PC_W-1:0] tgt,
                            input logic zwe, input logic zval, input logic run_after);
        obs_addr   = imem_addr;
        obs_stable = imem_req;
        for (int i = 0; i < waits; i++) begin
            tick();
            if (!imem_req || imem_addr !== obs_addr) obs_stable = 1'b0;
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        obs_valid  = op_valid;
        obs_op     = op;
        for (int i = 0; i < edly; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = ~word;
            tick();
        end
        imem_ack     = 1'b0;
        obs_req_exec = imem_req;
        obs_op_hold  = op;
        exec_done = 1'b1; pc_we = br; pc_in = tgt; zf_we = zwe; alu_zf = zval; run = run_after;
        tick();
        exec_done = 1'b0; pc_we = 1'b0; zf_we = 1'b0; alu_zf = 1'b0; pc_in = '0;
    endtask

    task automatic model_step(input logic br, input logic [PC_W-1:0] tgt,
                              input logic zwe, input logic zval);
        if (zwe) m_zf = zval;
        if (br) m_pc = tgt;
        else    m_pc = m_pc + 8'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        pc_in = '0; pc_we = 1'b0; alu_zf = 1'b0; zf_we = 1'b0;
        tick(); tick();
        n_vec++; if ({imem_req, op_valid, halted, zf} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got %b exp 0000", {imem_req, op_valid, halted, zf}); end
        n_vec++; if (pc !== 8'h00 || op !== 16'h0000) begin
            n_err++; $display("FAIL reset_pc_op got pc=%h op=%h exp 00/0000", pc, op); end
        rst_n = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b0) begin
            n_err++; $display("FAIL idle_no_req got %b exp 0", imem_req); end
        m_pc = '0; m_zf = 1'b0;
    endtask

    task automatic test_linear();
        logic [OP_W-1:0] w;
        logic [PC_W-1:0] ea;
        logic [OP_W-1:0] eo;
        run = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b1) begin
            n_err++; $display("FAIL run_to_req got %b exp 1", imem_req); end
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            q_addr.push_back(m_pc);
            q_op.push_back(w);
            do_instr((i % 2 == 1) ? 2 : 0, 1, w, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            model_step(1'b0, '0, 1'b0, 1'b0);
            ea = q_addr.pop_front();
            eo = q_op.pop_front();
            n_vec++; if (obs_addr !== ea || obs_stable !== 1'b1) begin
                n_err++; $display("FAIL lin_addr[%0d] got %h stable=%b exp %h stable=1", i, obs_addr, obs_stable, ea); end
            n_vec++; if (obs_valid !== 1'b1 || obs_op !== eo) begin
                n_err++; $display("FAIL lin_op[%0d] got valid=%b op=%h exp 1/%h", i, obs_valid, obs_op, eo); end
            n_vec++; if (obs_op_hold !== eo || obs_req_exec !== 1'b0) begin
                n_err++; $display("FAIL lin_hold[%0d] got op=%h req=%b exp %h/0", i, obs_op_hold, obs_req_exec, eo); end
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
                n_err++; $display("FAIL lin_period[%0d] got req=%b addr=%h exp 1/%h", i, imem_req, imem_addr, m_pc); end
        end
    endtask

    task automatic test_branch_flag();
        n_vec++; if (zf !== 1'b0 || imem_addr !== 8'h04) begin
            n_err++; $display("FAIL br_pre got zf=%b addr=%h exp 0/04", zf, imem_addr); end
        q_addr.push_back(m_pc);
        do_instr(0, 1, 16'h1234, 1'b1, 8'h20, 1'b1, 1'b1, 1'b1);
        model_step(1'b1, 8'h20, 1'b1, 1'b1);
        n_vec++; if (imem_addr !== m_pc || zf !== m_zf) begin
            n_err++; $display("FAIL br_take got addr=%h zf=%b exp %h/%b", imem_addr, zf, m_pc, m_zf); end
        q_addr.push_back(m_pc);
        do_instr(1, 0, 16'h5678, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        model_step(1'b0, '0, 1'b0, 1'b0);
        n_vec++; if (zf !== m_zf || imem_addr !== m_pc) begin
            n_err++; $display("FAIL zf_hold got zf=%b addr=%h exp %b/%h", zf, imem_addr, m_zf, m_pc); end
        void'(q_addr.pop_front());
        n_vec++; if (obs_addr !== q_addr[0]) begin
            n_err++; $display("FAIL br_fetch_addr got %h exp %h", obs_addr, q_addr[0]); end
        void'(q_addr.pop_front());
    endtask

    task automatic test_pause();
        do_instr(0, 1, 16'h0001, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1);
        model_step(1'b1, 8'h07, 1'b0, 1'b0);
        do_instr(0, 1, 16'h0707, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        model_step(1'b0, '0, 1'b0, 1'b0);
        n_vec++; if (imem_req !== 1'b0 || op_valid !== 1'b0 || pc !== m_pc) begin
            n_err++; $display("FAIL pause_idle got req=%b valid=%b pc=%h exp 0/0/%h", imem_req, op_valid, pc, m_pc); end
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 16'hBEEF;
            tick();
        end
        imem_ack = 1'b0;
        n_vec++; if (imem_req !== 1'b0 || op !== 16'h0707) begin
            n_err++; $display("FAIL pause_hold got req=%b op=%h exp 0/0707", imem_req, op); end
        run = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 8'h08) begin
            n_err++; $display("FAIL resume got req=%b addr=%h exp 1/08", imem_req, imem_addr); end
    endtask

    task automatic test_reset_midfetch();
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({imem_req, op_valid, halted, zf} !== 4'b0000 || pc !== 8'h00) begin
            n_err++; $display("FAIL async_reset got flags=%b pc=%h exp 0000/00", {imem_req, op_valid, halted, zf}, pc); end
        tick();
        imem_ack = 1'b0; rst_n = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || op !== 16'h0000) begin
            n_err++; $display("FAIL post_reset got req=%b addr=%h op=%h exp 1/00/0000", imem_req, imem_addr, op); end
        m_pc = '0; m_zf = 1'b0;
    endtask

    task automatic test_wrap();
        do_instr(0, 1, 16'h00FF, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        model_step(1'b1, 8'hFF, 1'b0, 1'b0);
        n_vec++; if (imem_addr !== 8'hFF) begin
            n_err++; $display("FAIL wrap_pre got %h exp ff", imem_addr); end
        do_instr(0, 1, 16'h0100, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        model_step(1'b0, '0, 1'b0, 1'b0);
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            n_err++; $display("FAIL wrap got req=%b addr=%h exp 1/%h", imem_req, imem_addr, m_pc); end
    endtask

    task automatic test_halt();
        int reqs;
        do_instr(0, 1, 16'h0010, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        do_instr(0, 1, 16'hE010, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
        n_vec++; if (halted !== 1'b1 || imem_req !== 1'b0 || op_valid !== 1'b0 || pc !== 8'h10) begin
            n_err++; $display("FAIL halt got h=%b req=%b valid=%b pc=%h exp 1/0/0/10", halted, imem_req, op_valid, pc); end
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (imem_req) reqs++;
        end
        n_vec++; if (reqs !== 0 || halted !== 1'b1) begin
            n_err++; $display("FAIL halt_quiet got reqs=%0d h=%b exp 0/1", reqs, halted); end
        run = 1'b0;
        tick();
        n_vec++; if (halted !== 1'b0 || pc !== 8'h00 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL unhalt got h=%b pc=%h req=%b exp 0/00/0", halted, pc, imem_req); end
        run = 1'b1;
        tick();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            n_err++; $display("FAIL restart got req=%b addr=%h exp 1/00", imem_req, imem_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_linear();
        test_branch_flag();
        test_pause();
        test_reset_midfetch();
        test_wrap();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
